imm_extend_pipe: RTL

- Parametrised, pipelined immediate-generation unit for the decode path.
- Takes the 24-bit instruction field and an immediate-source selector, and produces a DATA_W-bit immediate two cycles later.
- Modes: zero-extended, sign-extended, branch-offset and ARM-style rotated immediates.
- Valid/ready handshakes on both sides, a flush input and a tag pass-through, so it can sit between fetch and the register-read stage with backpressure.

---
 rtl/imm_extend_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate generator for the decode path: S1 captures the raw field,
// S2 holds the extended immediate. Valid/ready on both sides, flush drops everything.
module imm_extend_pipe #(
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [23:0]       instr_i,
    input  logic [2:0]        imm_src_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] imm_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              err_o
);

    localparam logic [2:0] SRC_ZEXT8  = 3'b000;
    localparam logic [2:0] SRC_ZEXT12 = 3'b001;
    localparam logic [2:0] SRC_BRANCH = 3'b010;
    localparam logic [2:0] SRC_ROT    = 3'b011;
    localparam logic [2:0] SRC_SEXT12 = 3'b100;

    logic              s1_valid_q, s1_valid_d;
    logic [23:0]       s1_instr_q, s1_instr_d;
    logic [2:0]        s1_src_q,   s1_src_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_imm_q,   s2_imm_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
    logic              s2_err_q,   s2_err_d;

    logic              s2_adv;
    logic              s1_adv;
    logic [DATA_W-1:0] imm_calc;
    logic              err_calc;
    logic [4:0]        rot_amt;
    logic [63:0]       rot_dbl;
    logic [31:0]       rot_val;

    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready_o = s1_adv;

    // Rotate right by shifting a doubled copy; the low word is the rotated value.
    always_comb begin
        rot_amt = {s1_instr_q[11:8], 1'b0};
        rot_dbl = {24'b0, s1_instr_q[7:0], 24'b0, s1_instr_q[7:0]} >> rot_amt;
        rot_val = rot_dbl[31:0];
    end

    always_comb begin
        imm_calc = '0;
        err_calc = 1'b0;
        case (s1_src_q)
            SRC_ZEXT8:  imm_calc = DATA_W'(s1_instr_q[7:0]);
            SRC_ZEXT12: imm_calc = DATA_W'(s1_instr_q[11:0]);
            SRC_BRANCH: imm_calc = DATA_W'($signed(s1_instr_q)) << BR_SHIFT;
            SRC_ROT:    imm_calc = DATA_W'(rot_val);
            SRC_SEXT12: imm_calc = DATA_W'($signed(s1_instr_q[11:0]));
            default: begin
                imm_calc = '0;
                err_calc = 1'b1;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        s1_src_d   = s1_src_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_imm_d = imm_calc;
                s2_tag_d = s1_tag_q;
                s2_err_d = err_calc;
            end
        end

        if (s1_adv) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_instr_d = instr_i;
                s1_src_d   = imm_src_i;
                s1_tag_d   = tag_i;
            end
        end

        // Flush wins over any handshake, including an input accepted this cycle.
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_src_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_instr_q <= s1_instr_d;
            s1_src_q   <= s1_src_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign imm_o       = s2_imm_q;
    assign tag_o       = s2_tag_q;
    assign err_o       = s2_err_q;

endmodule
